// File: rtl/store_narrow_unit_if.sv
// Store-unit bus interface: datapath store request/response and data memory write port.
// Signals: st_valid/st_ready/st_addr/st_data/st_size (store issue),
//          mem_req/mem_addr/mem_wdata/mem_be/mem_ack (memory write),
//          done/err/err_code/ovf (completion status).
// Modports: slave = the store unit, master = the store issuer / memory side.
interface store_narrow_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_size;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic              ovf;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ack,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_be, done, err, err_code, ovf
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ack,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_be, done, err, err_code, ovf
  );
endinterface

// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows a 32-bit register value to byte/half/word, places it on the
// correct lanes of a word-wide memory write, generates byte enables, checks alignment and
// flags values that do not survive narrowing. One store in flight at a time.
// Ports: clk, rst_n (async, active-low), sn_if (store_narrow_unit_if.slave).
// Optional feature: define STORE_SAT_EN to saturate overflowing narrowed values by sign
// instead of truncating them.
module store_narrow_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  store_narrow_unit_if.slave   sn_if
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] CODE_OK      = 2'b00;
  localparam logic [1:0] CODE_MISALGN = 2'b01;
  localparam logic [1:0] CODE_RSVD    = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RESP = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              ovf_q, ovf_d;
  logic              st_ready_q, mem_req_q, done_q;

  // Lane placement, byte enables, overflow and reject decode of the incoming store
  logic [31:0] d;
  logic [1:0]  a;
  logic        byte_ovf, half_ovf;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;
  logic        lane_ovf;
  logic        rej;
  logic [1:0]  rej_code;

  always_comb begin
    d        = sn_if.st_data;
    a        = sn_if.st_addr[1:0];
    // Value survives narrowing only if all bits above the kept sign bit match it
    byte_ovf = ~((&d[31:7])  | ~(|d[31:7]));
    half_ovf = ~((&d[31:15]) | ~(|d[31:15]));
`ifdef STORE_SAT_EN
    byte_val = byte_ovf ? (d[31] ? 8'h80 : 8'h7F) : d[7:0];
    half_val = half_ovf ? (d[31] ? 16'h8000 : 16'h7FFF) : d[15:0];
`else
    byte_val = d[7:0];
    half_val = d[15:0];
`endif
    lane_wdata = d;
    lane_be    = 4'b1111;
    lane_ovf   = 1'b0;
    rej        = 1'b0;
    rej_code   = CODE_OK;
    case (sn_if.st_size)
      2'b00: begin
        lane_wdata = {4{byte_val}};
        lane_be    = 4'b0001 << a;
        lane_ovf   = byte_ovf;
      end
      2'b01: begin
        lane_wdata = {2{half_val}};
        lane_be    = a[1] ? 4'b1100 : 4'b0011;
        lane_ovf   = half_ovf;
        if (a[0]) begin
          rej      = 1'b1;
          rej_code = CODE_MISALGN;
        end
      end
      2'b10: begin
        if (a != 2'b00) begin
          rej      = 1'b1;
          rej_code = CODE_MISALGN;
        end
      end
      default: begin
        rej      = 1'b1;
        rej_code = CODE_RSVD;
      end
    endcase
  end

  // Next-state and captured-store logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (sn_if.st_valid) begin
          if (rej) begin
            state_d    = S_RESP;
            err_d      = 1'b1;
            err_code_d = rej_code;
            ovf_d      = 1'b0;
          end else begin
            state_d     = S_REQ;
            cnt_d       = '0;
            mem_addr_d  = {sn_if.st_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = lane_wdata;
            mem_be_d    = lane_be;
            err_d       = 1'b0;
            err_code_d  = CODE_OK;
            ovf_d       = lane_ovf;
          end
        end
      end
      S_REQ: begin
        // Ack on the final timeout cycle still counts as success
        if (sn_if.mem_ack) begin
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = S_RESP;
          err_d      = 1'b1;
          err_code_d = CODE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; control outputs decode the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      err_q       <= 1'b0;
      err_code_q  <= CODE_OK;
      ovf_q       <= 1'b0;
      st_ready_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      ovf_q       <= ovf_d;
      st_ready_q  <= (state_d == S_IDLE);
      mem_req_q   <= (state_d == S_REQ);
      done_q      <= (state_d == S_RESP);
    end
  end

  assign sn_if.st_ready  = st_ready_q;
  assign sn_if.mem_req   = mem_req_q;
  assign sn_if.mem_addr  = mem_addr_q;
  assign sn_if.mem_wdata = mem_wdata_q;
  assign sn_if.mem_be    = mem_be_q;
  assign sn_if.done      = done_q;
  assign sn_if.err       = err_q;
  assign sn_if.err_code  = err_code_q;
  assign sn_if.ovf       = ovf_q;

endmodule
